// File: rtl/counter_down_load_if.sv
// Control/status bundle for the loadable down counter.
interface counter_down_load_if #(
  parameter int unsigned N = 4
);
  logic         load;
  logic [N-1:0] load_val;
  logic         mode;
  logic         en;
  logic [N-1:0] cnt;
  logic         tc;
  logic         busy;

  // Controller side: issues load/enable, observes count status.
  modport master (
    output load, load_val, mode, en,
    input  cnt, tc, busy
  );

  // Counter side.
  modport slave (
    input  load, load_val, mode, en,
    output cnt, tc, busy
  );
endinterface

// File: rtl/counter_down_load.sv
// Loadable, programmable-modulus down counter / timer.
// Counts a clamped load value down to 0, then stops (one-shot) or reloads
// (auto-reload), flagging each expiry on tc.
// Build option: define COUNTER_DOWN_LOAD_TC_COMB_EN for a combinational tc
// that rises during the expiry cycle instead of the cycle after it.
module counter_down_load #(
  parameter int unsigned N   = 4,
  parameter int unsigned MAX = 8
) (
  input  logic                clock,
  input  logic                reset,
  counter_down_load_if.slave  s
);

  localparam logic [N-1:0] MAX_V = N'(MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_nx;
  logic [N-1:0] cnt_q, cnt_nx;
  logic [N-1:0] reload_q, reload_nx;
  logic         mode_q, mode_nx;
  logic [N-1:0] load_clamped;
  logic         expire;

  // Clamp the requested start value to the programmed modulus.
  always_comb begin
    load_clamped = (s.load_val > MAX_V) ? MAX_V : s.load_val;
  end

  // Next-state, next-count and expiry decode.
  always_comb begin
    state_nx  = state_q;
    cnt_nx    = cnt_q;
    reload_nx = reload_q;
    mode_nx   = mode_q;
    expire    = 1'b0;
    if (s.load) begin
      cnt_nx    = load_clamped;
      reload_nx = load_clamped;
      mode_nx   = s.mode;
      state_nx  = RUN;
    end else if (state_q == RUN && s.en) begin
      if (cnt_q != '0) begin
        cnt_nx = cnt_q - N'(1);
      end else begin
        expire = 1'b1;
        if (mode_q) begin
          cnt_nx = reload_q;
        end else begin
          state_nx = DONE;
        end
      end
    end
  end

  // State, count and configuration registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= MAX_V;
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_nx;
      cnt_q    <= cnt_nx;
      reload_q <= reload_nx;
      mode_q   <= mode_nx;
    end
  end

`ifdef COUNTER_DOWN_LOAD_TC_COMB_EN
  // Expiry flag during the expiry cycle itself.
  always_comb begin
    s.tc = expire & reset;
  end
`else
  logic tc_q;

  // Expiry flag for the cycle following the expiry edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      tc_q <= 1'b0;
    end else begin
      tc_q <= expire;
    end
  end

  assign s.tc = tc_q;
`endif

  assign s.cnt  = cnt_q;
  assign s.busy = (state_q == RUN);

endmodule

// File: doc/counter_down_load.md
Name: counter_down_load

Overview:
- Loadable, programmable-modulus down counter/timer. It is the count-down counterpart of the team's modulo up counter.
- Counts from a loaded value down to 0, then either stops (one-shot) or reloads (auto-reload).
- Emits a terminal-count pulse on each expiry.
- Used as a tick divider or timeout timer feeding control FSMs.

Parameters:
- N, 4, counter width in bits.
- MAX, 8, largest count value; load values above MAX are clamped to MAX. Legal range is 1 <= MAX <= 2**N-1.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- load  input  1  load strobe; captures load_val.
- load_val  input  N  start/reload value.
- mode  input  1  0 = one-shot, 1 = auto-reload; sampled only on load.
- en  input  1  count enable.
- cnt  output  N  current count.
- tc  output  1  terminal-count pulse.
- busy  output  1  high while in RUN.

Behaviour:
- All state updates on the rising clock edge. There is one clock and no asynchronous paths.
- reset==0 at an edge, regardless of other inputs:
  - state=IDLE, cnt=0, tc=0, busy=0.
  - reload register=MAX, mode register=0.
- Reset mid-count: the counter aborts cleanly at the next edge. No tc is generated.
- Clamping: the loaded value is L = min(load_val, MAX).
- States:
  - IDLE: after reset, before any load. busy=0, cnt=0.
  - RUN: counting. busy=1.
  - DONE: one-shot expired. busy=0, cnt holds 0.
- Load (highest priority after reset), accepted in any state:
  - Registers L into cnt and into the reload register, and registers mode.
  - Next state is RUN, also when L=0.
  - A load at an edge suppresses any tc that edge would otherwise produce.
- RUN with en=1, no load:
  - If cnt != 0: cnt <= cnt-1.
  - If cnt == 0: expiry.
    - Auto-reload: cnt <= reload register, stay in RUN.
    - One-shot: cnt stays 0, go to DONE.
- RUN with en=0: cnt and state hold, no tc.
- IDLE/DONE: en is ignored, cnt and state hold.
- Period: auto-reload period is L+1 enabled cycles. With MAX=8 and L=8 this is a modulo-9 down count 8..0.
- tc (default build): registered. It is 1 for exactly the one cycle following the expiry edge, otherwise 0.
- Back-to-back expiries with L=0 in auto-reload: tc is 1 on every enabled cycle.
- Arithmetic: N-bit unsigned. cnt never decrements below 0, with no wrap to 2**N-1. Values above MAX never appear on cnt.

Optional Feature:
- Macro: COUNTER_DOWN_LOAD_TC_COMB_EN.
- Defined: tc is combinational, tc = busy & en & (cnt==0) & ~load & reset. It is high during the expiry cycle itself, one cycle earlier than the default.
- Undefined: registered tc as specified in Behaviour.
- cnt and busy timing are identical in both builds.

Test Plan:
- Reset: hold reset=0 for 2 edges with load=1, load_val=5 -> cnt=0, tc=0, busy=0 after each edge; load is ignored.
- One-shot: load=1, load_val=3, mode=0 for one edge, then en=1 -> cnt 3,2,1,0 on successive edges; tc=1 for exactly one cycle after the expiry edge (registered build) or during the cnt==0 cycle (macro build); then busy=0, cnt stays 0 for 5 more edges.
- Auto-reload plus clamp: load_val=12, mode=1, en=1 -> cnt=8 after load, then 7..0,8,7..; tc pulses every 9 cycles over 3 periods; busy stays 1.
- Enable gating: one-shot with L=4, drop en for 3 cycles at cnt=2 -> cnt holds 2, no tc; resumes 1,0 when en=1.
- Load collision: auto-reload with L=2, assert load with load_val=6 on the edge where cnt==0 -> cnt=6 next, no tc that cycle.
- Reset mid-operation: reset=0 for one edge while cnt=5 in RUN -> cnt=0, busy=0, tc=0 next cycle; no further counting until a load.
